// File: rtl/multicycle_cu_pkg.sv
// Shared types and constants for the multi-cycle control unit.
// FSM states, ALU op encodings and the default multi-cycle op mask.
package cu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    WAIT,
    WB
  } state_t;

  localparam int OP_NOT = 0;
  localparam int OP_SHL = 1;
  localparam int OP_SHR = 2;
  localparam int OP_AND = 3;
  localparam int OP_OR  = 4;
  localparam int OP_ADD = 5;

  // SHL and SHR run on the iterative shifter
  localparam logic [31:0] DEF_MULTI_MASK = 32'h0000_0006;

endpackage

// File: rtl/multicycle_cu_if.sv
// Instruction handshake and ALU control bundle of the control unit.
// The master side issues opcodes and reports ALU completion.
interface multicycle_cu_if #(
  parameter int OPCODE_W = 4
);
  localparam int AOP_W = OPCODE_W - 1;

  logic                instr_valid;
  logic                instr_ready;
  logic [OPCODE_W-1:0] opcode;
  logic                alu_done;
  logic [AOP_W-1:0]    alu_op;
  logic                imm_sel;
  logic                alu_start;
  logic                reg_en;
  logic                busy;
  logic                done;
  logic                illegal;
  logic                timeout;

  modport master (
    output instr_valid, opcode, alu_done,
    input  instr_ready, alu_op, imm_sel, alu_start,
    input  reg_en, busy, done, illegal, timeout
  );

  modport slave (
    input  instr_valid, opcode, alu_done,
    output instr_ready, alu_op, imm_sel, alu_start,
    output reg_en, busy, done, illegal, timeout
  );

endinterface

// File: rtl/multicycle_cu_op_decode.sv
// ALU op field classifier: legality and multi-cycle flag.
// Shared with the assembler checker.
module cu_op_decode
  import cu_pkg::*;
#(
  parameter int          AOP_W      = 3,
  parameter int          NUM_OPS    = 6,
  parameter logic [31:0] MULTI_MASK = DEF_MULTI_MASK
) (
  input  logic [AOP_W-1:0] op,
  output logic             is_legal,
  output logic             is_multi
);

  localparam int N = 2 ** AOP_W;
  localparam logic [N-1:0] MASK = MULTI_MASK[N-1:0];

  always_comb begin
    is_legal = 32'(op) < 32'(NUM_OPS);
    is_multi = is_legal & MASK[op];
  end

endmodule

// File: rtl/multicycle_cu.sv
// Sequential control unit: accept, decode, execute, wait, write back.
// Every output is a flop loaded from the next-state decision.
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int          OPCODE_W   = 4,
  parameter int          NUM_OPS    = 6,
  parameter logic [31:0] MULTI_MASK = DEF_MULTI_MASK,
  parameter int          TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_cu_if.slave        bus
);

  localparam int AOP_W = OPCODE_W - 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state;
  state_t              state_nx;
  logic [OPCODE_W-1:0] op_q;
  logic [CNT_W-1:0]    cnt;
  logic                is_legal;
  logic                is_multi;
  logic                accept;
  logic                expired;

  logic                ready_q, ready_nx;
  logic                busy_q, busy_nx;
  logic                start_q, start_nx;
  logic                wb_q, wb_nx;
  logic                ill_q, ill_nx;
  logic                to_q, to_nx;
  logic [AOP_W-1:0]    aop_q;
  logic                imm_q;

  cu_op_decode #(
    .AOP_W      (AOP_W),
    .NUM_OPS    (NUM_OPS),
    .MULTI_MASK (MULTI_MASK)
  ) u_dec (
    .op       (op_q[AOP_W-1:0]),
    .is_legal (is_legal),
    .is_multi (is_multi)
  );

  assign accept  = bus.instr_valid & ready_q;
  assign expired = cnt == CNT_LAST;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = DECODE;
      DECODE:  state_nx = is_legal ? EXEC : IDLE;
      EXEC:    state_nx = is_multi ? WAIT : WB;
      WAIT: begin
        // a completion on the last allowed cycle still counts
        if (bus.alu_done)  state_nx = WB;
        else if (expired)  state_nx = IDLE;
      end
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready_nx = state_nx == IDLE;
    busy_nx  = state_nx != IDLE;
    start_nx = state_nx == EXEC;
    wb_nx    = state_nx == WB;
    ill_nx   = (state == DECODE) & ~is_legal;
    to_nx    = (state == WAIT) & ~bus.alu_done & expired;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      wb_q    <= 1'b0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
      aop_q   <= '0;
      imm_q   <= 1'b0;
      op_q    <= '0;
      cnt     <= '0;
    end else begin
      ready_q <= ready_nx;
      busy_q  <= busy_nx;
      start_q <= start_nx;
      wb_q    <= wb_nx;
      ill_q   <= ill_nx;
      to_q    <= to_nx;
      if (accept) op_q <= bus.opcode;
      if (state == DECODE) begin
        aop_q <= op_q[AOP_W-1:0];
        imm_q <= op_q[OPCODE_W-1];
      end
      if (state == EXEC)      cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.alu_start   = start_q;
  assign bus.reg_en      = wb_q;
  assign bus.done        = wb_q;
  assign bus.illegal     = ill_q;
  assign bus.timeout     = to_q;
  assign bus.alu_op      = aop_q;
  assign bus.imm_sel     = imm_q;

endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
- Parametrised, sequential successor to the combinational 2-bit control unit.
- Accepts one instruction opcode through a valid/ready handshake, decodes it, and sequences the ALU through a decode/execute/(wait)/writeback FSM.
- Opcode MSB selects the immediate operand; the remaining bits are the ALU operation. Same mapping as before: with OPCODE_W=2, op 0 = NOT and op 1 = SHL.
- Adds multi-cycle ALU ops with a done handshake, illegal-op detection and a wait timeout.

Parameters:
- OPCODE_W, 4, opcode width; ALU op field = OPCODE_W-1 bits (derived localparam AOP_W).
- NUM_OPS, 6, legal ALU ops are 0..NUM_OPS-1 (0 NOT, 1 SHL, 2 SHR, 3 AND, 4 OR, 5 ADD); must be <= 2**AOP_W.
- MULTI_MASK, 6 (bits 1,2 set), bit i set means ALU op i is multi-cycle (iterative shifter).
- TIMEOUT, 16, maximum WAIT cycles before abort; counter width = $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- instr_valid  in  1  opcode present.
- instr_ready  out  1  CU can accept an opcode.
- opcode  in  OPCODE_W  MSB = imm select, low AOP_W bits = ALU op.
- alu_done  in  1  multi-cycle ALU op finished.
- alu_op  out  AOP_W  registered ALU operation.
- imm_sel  out  1  registered immediate-operand select.
- alu_start  out  1  one-cycle ALU start pulse.
- reg_en  out  1  one-cycle register-file write enable.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse, coincident with reg_en.
- illegal  out  1  one-cycle pulse on an undefined ALU op.
- timeout  out  1  one-cycle pulse on a WAIT abort.

Behaviour:
- Reset, sampled on the clk edge while rst_n=0:
  - state = IDLE.
  - All outputs 0 except instr_ready = 1.
  - Wait counter = 0.
- Reset overrides any state, including mid-WAIT; the instruction in flight is discarded.
- All outputs are registered.
- IDLE:
  - instr_ready = 1.
  - The handshake completes on an edge where instr_valid & instr_ready; opcode is latched and the FSM moves to DECODE.
  - instr_valid is ignored in every other state (instr_ready = 0 there).
- DECODE (1 cycle):
  - alu_op and imm_sel are loaded from the latched opcode.
  - If alu_op >= NUM_OPS: illegal pulses in the following cycle, the FSM returns to IDLE, and there is no alu_start or reg_en.
  - Otherwise the FSM moves to EXEC.
- EXEC (1 cycle):
  - alu_start = 1.
  - Single-cycle op: next state WB.
  - MULTI_MASK[alu_op] set: next state WAIT, wait counter cleared.
  - alu_done is not sampled in EXEC.
- WAIT:
  - The counter increments each cycle.
  - alu_done = 1: next state WB.
  - Counter reaches TIMEOUT-1 with alu_done = 0: timeout pulses in the following cycle, the FSM returns to IDLE, and there is no reg_en.
  - alu_done and expiry in the same cycle: alu_done wins.
- WB (1 cycle): reg_en = 1 and done = 1; next state IDLE.
- alu_op and imm_sel hold their values from DECODE until the next DECODE; they do not clear on return to IDLE.
- Latency, handshake at edge N:
  - DECODE in cycle N+1.
  - alu_start in N+2.
  - Single-cycle op: reg_en/done in N+3, instr_ready back in N+4.
  - Multi-cycle op: alu_done sampled at edge M gives reg_en at M+1.
- Throughput: at most one instruction per 4 cycles; there is no overlap.

Decomposition:
- cu_pkg holds:
  - FSM state enum (IDLE, DECODE, EXEC, WAIT, WB).
  - ALU op encodings (OP_NOT=0, OP_SHL=1, OP_SHR=2, OP_AND=3, OP_OR=4, OP_ADD=5).
  - Default MULTI_MASK constant.
- Sub-module cu_op_decode: combinational, takes the ALU op field and outputs is_legal and is_multi. It is reused by the assembler checker.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with instr_valid=1 -> all outputs 0, instr_ready=1, busy=0; no accept until rst_n=1.
- opcode=4'b0000 (reg NOT), valid at edge 0 -> alu_start in cycle 2; reg_en=done=1 in cycle 3; alu_op=000, imm_sel=0; instr_ready=1 in cycle 4.
- opcode=4'b1001 (imm SHL, multi-cycle), alu_done raised 5 cycles after alu_start -> reg_en exactly 1 cycle after alu_done; imm_sel=1 held throughout; busy high from cycle 1 through WB.
- opcode=4'b0111 (op 7, illegal) -> illegal pulse in cycle 2, no alu_start, no reg_en; next opcode accepted in cycle 2.
- opcode=4'b0010 (SHR), alu_done never asserted -> timeout pulse after 16 WAIT cycles, no reg_en/done, return to IDLE. Variant with alu_done on the expiry cycle -> reg_en, no timeout.
- rst_n=0 for 1 cycle mid-WAIT -> all outputs 0 at the next edge; a fresh opcode 4'b0011 then completes normally with reg_en in cycle 3.
